seg_display_mux: RTL and testbench

SEG_DISPLAY_MUX -- requirements
Module: seg_display_mux

---
 rtl/seg_display_mux.sv | 117 +++++++++++
 tb/tb_seg_display_mux.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/seg_display_mux.sv
// seg_display_mux
//   Time-multiplexed 4-digit 7-segment driver for an mm.ss stopwatch.
//   Each digit gets one slot of REFRESH_DIV clk cycles. The first BLANK_CYC
//   cycles of every slot keep all anodes off so the previous digit's
//   segments cannot ghost onto the next anode. Inputs are sampled once per
//   frame, at the last cycle of slot 3, so all four digits come from one
//   coherent minutes/seconds pair.
//
// Ports
//   clk     : rising-edge clock
//   reset   : asynchronous, active-high reset
//   seconds : binary seconds, 0-59 nominal (60-63 shown as dashes)
//   minutes : binary minutes, 0-59 nominal (60-63 shown as dashes)
//   an      : active-low anodes, an[0] = rightmost digit (seconds ones)
//   seg     : active-low cathodes {g,f,e,d,c,b,a}
//   dp      : active-low decimal point, lit on digit 2 (mm.ss)
module seg_display_mux #(
    parameter int REFRESH_DIV = 100000,
    parameter int BLANK_CYC   = 1000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] seconds,
    input  logic [5:0] minutes,
    output logic [3:0] an,
    output logic [6:0] seg,
    output logic       dp
);
    localparam int            CW     = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CW-1:0] TC_V   = CW'(REFRESH_DIV - 1);
    localparam logic [CW-1:0] BLANK_V = CW'(BLANK_CYC);

    logic [CW-1:0] cnt;
    logic [1:0]    idx;
    logic [5:0]    snap_s, snap_m;
    logic          tc, blank;

    assign tc = (cnt == TC_V);

    // With BLANK_CYC = 0 the comparison would be constant-false; make that explicit.
    generate
        if (BLANK_CYC == 0) begin : g_noblank
            assign blank = 1'b0;
        end else begin : g_blank
            assign blank = (cnt < BLANK_V);
        end
    endgenerate

    // Refresh counter, digit index and frame snapshot.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt    <= '0;
            idx    <= 2'd0;
            snap_s <= 6'd0;
            snap_m <= 6'd0;
        end else if (tc) begin
            cnt <= '0;
            idx <= idx + 2'd1;
            if (idx == 2'd3) begin
                snap_s <= seconds;
                snap_m <= minutes;
            end
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

    function automatic logic [6:0] seg_of(input logic [3:0] d);
        case (d)
            4'd0:    seg_of = 7'h40;
            4'd1:    seg_of = 7'h79;
            4'd2:    seg_of = 7'h24;
            4'd3:    seg_of = 7'h30;
            4'd4:    seg_of = 7'h19;
            4'd5:    seg_of = 7'h12;
            4'd6:    seg_of = 7'h02;
            4'd7:    seg_of = 7'h78;
            4'd8:    seg_of = 7'h00;
            4'd9:    seg_of = 7'h10;
            default: seg_of = 7'h7F;
        endcase
    endfunction

    // Next-output decode from the current count/index/snapshot.
    logic [5:0] fld;
    logic [3:0] dig;
    logic [3:0] an_d;
    logic [6:0] seg_d;
    logic       dp_d;

    always_comb begin
        an_d  = 4'hF;
        seg_d = 7'h7F;
        dp_d  = 1'b1;
        fld   = idx[1] ? snap_m : snap_s;
        // Odd index = tens digit of the selected field.
        dig   = idx[0] ? 4'(fld / 6'd10) : 4'(fld % 6'd10);
        if (!blank) begin
            an_d       = 4'hF;
            an_d[idx]  = 1'b0;
            seg_d      = (fld > 6'd59) ? 7'h3F : seg_of(dig);
            dp_d       = (idx != 2'd2);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            an  <= 4'hF;
            seg <= 7'h7F;
            dp  <= 1'b1;
        end else begin
            an  <= an_d;
            seg <= seg_d;
            dp  <= dp_d;
        end
    end
endmodule

// File: tb/tb_seg_display_mux.sv
module tb_seg_display_mux;
    localparam int RD = 4;
    localparam int BC = 1;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [5:0] seconds = 6'd0;
    logic [5:0] minutes = 6'd0;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;

    seg_display_mux #(.REFRESH_DIV(RD), .BLANK_CYC(BC)) dut (
        .clk(clk), .reset(reset), .seconds(seconds), .minutes(minutes),
        .an(an), .seg(seg), .dp(dp)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] an;
        logic [6:0] seg;
        logic       dp;
    } exp_t;

    exp_t exp_q[$];
    int   compared = 0;
    int   mismatched = 0;

    // Reference model state: cycles since reset release and frame snapshot.
    int   n = 0;
    int   ms = 0, mm = 0;
    logic [6:0] tbl [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                             7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

    function automatic exp_t model(int cyc, int ss, int sm);
        exp_t e;
        int pos, slot, v, d;
        pos  = cyc % RD;
        slot = (cyc / RD) % 4;
        e.an = 4'hF; e.seg = 7'h7F; e.dp = 1'b1;
        if (pos >= BC) begin
            e.an = 4'hF & ~(4'h1 << slot);
            v = (slot < 2) ? ss : sm;
            if (v > 59) e.seg = 7'h3F;
            else begin
                d = (slot % 2 == 0) ? v % 10 : v / 10;
                e.seg = tbl[d];
            end
            e.dp = (slot != 2);
        end
        return e;
    endfunction

    // Called at a negedge: applies inputs, predicts the output the next edge
    // registers, then waits for the following negedge.
    task automatic step(input int s, input int m);
        seconds = 6'(s);
        minutes = 6'(m);
        exp_q.push_back(model(n, ms, mm));
        if (n % (4 * RD) == 4 * RD - 1) begin
            ms = s;
            mm = m;
        end
        n++;
        @(negedge clk);
    endtask

    task automatic chk_blank(input string name);
        compared++;
        if (an !== 4'hF || seg !== 7'h7F || dp !== 1'b1) begin
            mismatched++;
            $display("FAIL %s: got an=%h seg=%h dp=%b, need an=F seg=7F dp=1",
                     name, an, seg, dp);
        end
    endtask

    // Monitor: scoreboard compare plus one-hot / dp invariants every cycle.
    always @(posedge clk) begin
        exp_t e;
        #1;
        compared++;
        if (!(an inside {4'hE, 4'hD, 4'hB, 4'h7, 4'hF}) || (dp === 1'b0 && an !== 4'hB)) begin
            mismatched++;
            $display("FAIL invariant: got an=%h dp=%b, need one-hot an and dp=0 only with an=B", an, dp);
        end
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            compared++;
            if (an !== e.an || seg !== e.seg || dp !== e.dp) begin
                mismatched++;
                $display("FAIL scoreboard t=%0t: got an=%h seg=%h dp=%b, need an=%h seg=%h dp=%b",
                         $time, an, seg, dp, e.an, e.seg, e.dp);
            end
        end
    end

    task automatic do_reset(input string name);
        reset = 1'b1;
        #1;
        chk_blank(name);
        exp_q.delete();
        n = 0; ms = 0; mm = 0;
        repeat (3) @(negedge clk);
        chk_blank({name, "_held"});
        reset = 1'b0;
    endtask

    initial begin
        // Power-on reset, then 00.00 frame.
        @(negedge clk);
        do_reset("reset_initial");
        repeat (16) step(34, 12);
        // 12:34 frame (sampled at end of previous frame).
        repeat (16) step(34, 12);
        // Coherence: seconds changes during index-1 slot.
        repeat (6) step(34, 12);
        repeat (26) step(35, 12);
        // Out-of-range seconds, minutes 07.
        repeat (32) step(61, 7);
        // Out-of-range minutes.
        repeat (32) step(9, 63);
        // Wrap 59:59 -> 00:00.
        repeat (16) step(59, 59);
        repeat (16) step(0, 0);
        repeat (16) step(0, 0);
        // Mid-frame reset.
        repeat (7) step(21, 45);
        #2;
        do_reset("reset_midframe");
        repeat (20) step(21, 45);
        // Random inputs, including out-of-range values.
        begin
            int s, m;
            s = 0; m = 0;
            for (int i = 0; i < 1000; i++) begin
                if ($urandom_range(0, 7) == 0) s = $urandom_range(0, 63);
                if ($urandom_range(0, 7) == 0) m = $urandom_range(0, 63);
                step(s, m);
            end
        end
        @(posedge clk);
        #2;
        compared++;
        if (exp_q.size() != 0) begin
            mismatched++;
            $display("FAIL drain: got %0d pending, need 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
